// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB bundle plus register-file write and forwarding outputs
interface wb_stage_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 16
);
  logic             valid_i;
  logic             flush_i;
  logic             regwe_i;
  logic [1:0]       cregwa_i;
  logic [1:0]       cregwd_i;
  logic [2:0]       ldsel_i;
  logic [AW-1:0]    rt_i;
  logic [AW-1:0]    rd_i;
  logic [31:0]      aluout_i;
  logic [31:0]      pc_i;
  logic [31:0]      memrd_i;
  logic             memrd_vld_i;
  logic             we;
  logic [AW-1:0]    wa;
  logic [31:0]      wd;
  logic             we_wb;
  logic [AW-1:0]    wa_wb;
  logic [31:0]      wd_wb;
  logic             wb_busy_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output valid_i, flush_i, regwe_i, cregwa_i, cregwd_i, ldsel_i,
           rt_i, rd_i, aluout_i, pc_i, memrd_i, memrd_vld_i,
    input  we, wa, wd, we_wb, wa_wb, wd_wb, wb_busy_o, retired_o
  );

  modport slave (
    input  valid_i, flush_i, regwe_i, cregwa_i, cregwd_i, ldsel_i,
           rt_i, rd_i, aluout_i, pc_i, memrd_i, memrd_vld_i,
    output we, wa, wd, we_wb, wa_wb, wd_wb, wb_busy_o, retired_o
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, load alignment, write-back mux, load stall and retire counter
module wb_stage #(
  parameter int AW       = 5,
  parameter int LINK_REG = 31,
  parameter int LINK_OFS = 8,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  logic             valid_q;
  logic             regwe_q;
  logic [1:0]       cregwd_q;
  logic [2:0]       ldsel_q;
  logic [AW-1:0]    wa_q;
  logic [31:0]      alu_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             is_load;
  logic             busy;
  logic             adv;
  logic [AW-1:0]    wa_sel;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_val;
  logic [31:0]      wd_sel;
  logic             we_int;

  assign is_load = valid_q && (cregwd_q == 2'd1);
  assign busy    = is_load && !bus.memrd_vld_i;
  assign adv     = !busy;

  // Destination is resolved in MEM so WB only stores the final address.
  always_comb begin
    wa_sel = bus.rt_i;
    case (bus.cregwa_i)
      2'd1:    wa_sel = bus.rd_i;
      2'd2:    wa_sel = AW'(LINK_REG);
      default: wa_sel = bus.rt_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      regwe_q  <= 1'b0;
      cregwd_q <= 2'd0;
      ldsel_q  <= 3'd0;
      wa_q     <= '0;
      alu_q    <= 32'd0;
      pc_q     <= 32'd0;
    end else if (adv) begin
      valid_q  <= bus.valid_i && !bus.flush_i;
      regwe_q  <= bus.regwe_i;
      cregwd_q <= bus.cregwd_i;
      ldsel_q  <= bus.ldsel_i;
      wa_q     <= wa_sel;
      alu_q    <= bus.aluout_i;
      pc_q     <= bus.pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (valid_q && !busy) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    ld_byte = bus.memrd_i[31:24];
    case (alu_q[1:0])
      2'd1:    ld_byte = bus.memrd_i[23:16];
      2'd2:    ld_byte = bus.memrd_i[15:8];
      2'd3:    ld_byte = bus.memrd_i[7:0];
      default: ld_byte = bus.memrd_i[31:24];
    endcase
  end

  assign ld_half = alu_q[1] ? bus.memrd_i[15:0] : bus.memrd_i[31:16];

  always_comb begin
    ld_val = bus.memrd_i;
    case (ldsel_q)
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_val = {16'd0, ld_half};
      3'd3:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_val = {24'd0, ld_byte};
      default: ld_val = bus.memrd_i;
    endcase
  end

  always_comb begin
    wd_sel = alu_q;
    case (cregwd_q)
      2'd1:    wd_sel = ld_val;
      2'd2:    wd_sel = pc_q + 32'(LINK_OFS);
      2'd3:    wd_sel = 32'd0;
      default: wd_sel = alu_q;
    endcase
  end

  assign we_int = valid_q && regwe_q && !busy && (wa_q != '0);

  assign bus.we        = we_int;
  assign bus.wa        = wa_q;
  assign bus.wd        = wd_sel;
  assign bus.we_wb     = we_int;
  assign bus.wa_wb     = wa_q;
  assign bus.wd_wb     = wd_sel;
  assign bus.wb_busy_o = busy;
  assign bus.retired_o = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wb_stage_if #(.AW(5), .CNT_W(16)) bus ();

  wb_stage #(.AW(5), .LINK_REG(31), .LINK_OFS(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic f, input logic rwe,
                       input logic [1:0] ca, input logic [1:0] cd, input logic [2:0] ls,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc);
    bus.valid_i  = v;
    bus.flush_i  = f;
    bus.regwe_i  = rwe;
    bus.cregwa_i = ca;
    bus.cregwd_i = cd;
    bus.ldsel_i  = ls;
    bus.rt_i     = rt;
    bus.rd_i     = rd;
    bus.aluout_i = alu;
    bus.pc_i     = pc;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    nop();
    bus.memrd_i = 32'd0;
    bus.memrd_vld_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %0h want 0", bus.we); end
      n_cmp++; if (bus.wa !== 5'd0) begin n_err++; $display("FAIL rst_wa: got %0h want 0", bus.wa); end
      n_cmp++; if (bus.wd !== 32'd0) begin n_err++; $display("FAIL rst_wd: got %0h want 0", bus.wd); end
      n_cmp++; if (bus.wb_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", bus.wb_busy_o); end
      n_cmp++; if (bus.retired_o !== 16'd0) begin n_err++; $display("FAIL rst_ret: got %0d want 0", bus.retired_o); end
    end
    rst = 1'b1;
    step();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL post_rst_we: got %0h want 0", bus.we); end
    n_cmp++; if (bus.retired_o !== 16'd0) begin n_err++; $display("FAIL post_rst_ret: got %0d want 0", bus.retired_o); end
  endtask

  task automatic test_alu_writes();
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd5, 32'h1234, 32'h0);
    step();
    n_cmp++; if (bus.we !== 1'b1) begin n_err++; $display("FAIL alu1_we: got %0h want 1", bus.we); end
    n_cmp++; if (bus.wa !== 5'd5) begin n_err++; $display("FAIL alu1_wa: got %0d want 5", bus.wa); end
    n_cmp++; if (bus.wd !== 32'h1234) begin n_err++; $display("FAIL alu1_wd: got %h want 00001234", bus.wd); end
    n_cmp++; if (bus.we_wb !== 1'b1 || bus.wa_wb !== 5'd5 || bus.wd_wb !== 32'h1234) begin
      n_err++; $display("FAIL alu1_fwd: got %0h/%0d/%h want 1/5/00001234", bus.we_wb, bus.wa_wb, bus.wd_wb);
    end
    drive(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 5'd7, 5'd3, 32'hDEAD, 32'h0);
    step();
    n_cmp++; if (bus.we !== 1'b1) begin n_err++; $display("FAIL alu2_we: got %0h want 1", bus.we); end
    n_cmp++; if (bus.wa !== 5'd7) begin n_err++; $display("FAIL alu2_wa: got %0d want 7", bus.wa); end
    n_cmp++; if (bus.wd !== 32'hDEAD) begin n_err++; $display("FAIL alu2_wd: got %h want 0000dead", bus.wd); end
    n_cmp++; if (bus.retired_o !== 16'd1) begin n_err++; $display("FAIL alu2_ret: got %0d want 1", bus.retired_o); end
    nop();
    step();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL alu_nop_we: got %0h want 0", bus.we); end
    n_cmp++; if (bus.retired_o !== 16'd2) begin n_err++; $display("FAIL alu_ret: got %0d want 2", bus.retired_o); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  ls  [6] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};
    logic [1:0]  ofs [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h000000FF, 32'h0000007F,
                             32'h00007F01, 32'h000080FF, 32'h80FF7F01};
    bus.memrd_i = 32'h80FF7F01;
    bus.memrd_vld_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, ls[i], 5'd0, 5'd3, {30'h400, ofs[i]}, 32'h0);
      step();
      n_cmp++; if (bus.we !== 1'b1 || bus.wa !== 5'd3) begin
        n_err++; $display("FAIL ld%0d_we: got %0h/%0d want 1/3", i, bus.we, bus.wa);
      end
      n_cmp++; if (bus.wd !== exp[i]) begin n_err++; $display("FAIL ld%0d_wd: got %h want %h", i, bus.wd, exp[i]); end
      n_cmp++; if (bus.retired_o !== 16'(2 + i)) begin n_err++; $display("FAIL ld%0d_ret: got %0d want %0d", i, bus.retired_o, 2 + i); end
    end
    nop();
    step();
    n_cmp++; if (bus.retired_o !== 16'd8) begin n_err++; $display("FAIL ld_ret: got %0d want 8", bus.retired_o); end
  endtask

  task automatic test_load_stall();
    bus.memrd_vld_i = 1'b0;
    bus.memrd_i = 32'hDEADBEEF;
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 5'd0, 5'd9, 32'h2000, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd10, 32'hAAAA, 32'h0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus.wb_busy_o !== 1'b1) begin n_err++; $display("FAIL stall%0d_busy: got %0h want 1", c, bus.wb_busy_o); end
      n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL stall%0d_we: got %0h want 0", c, bus.we); end
      n_cmp++; if (bus.wa !== 5'd9) begin n_err++; $display("FAIL stall%0d_wa: got %0d want 9", c, bus.wa); end
      n_cmp++; if (bus.retired_o !== 16'd8) begin n_err++; $display("FAIL stall%0d_ret: got %0d want 8", c, bus.retired_o); end
      bus.flush_i = (c == 1);
      if (c < 2) step();
    end
    bus.flush_i = 1'b0;
    bus.memrd_i = 32'h11223344;
    bus.memrd_vld_i = 1'b1;
    #1;
    n_cmp++; if (bus.wb_busy_o !== 1'b0) begin n_err++; $display("FAIL stall_rel_busy: got %0h want 0", bus.wb_busy_o); end
    n_cmp++; if (bus.we !== 1'b1 || bus.wa !== 5'd9) begin
      n_err++; $display("FAIL stall_rel_we: got %0h/%0d want 1/9", bus.we, bus.wa);
    end
    n_cmp++; if (bus.wd !== 32'h11223344) begin n_err++; $display("FAIL stall_rel_wd: got %h want 11223344", bus.wd); end
    step();
    n_cmp++; if (bus.retired_o !== 16'd9) begin n_err++; $display("FAIL stall_ret: got %0d want 9", bus.retired_o); end
    n_cmp++; if (bus.we !== 1'b1 || bus.wa !== 5'd10 || bus.wd !== 32'hAAAA) begin
      n_err++; $display("FAIL stall_next: got %0h/%0d/%h want 1/10/0000aaaa", bus.we, bus.wa, bus.wd);
    end
    nop();
    step();
    n_cmp++; if (bus.retired_o !== 16'd10) begin n_err++; $display("FAIL stall_ret2: got %0d want 10", bus.retired_o); end
  endtask

  task automatic test_link_r0();
    drive(1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 3'd0, 5'd4, 5'd6, 32'h0, 32'h00400010);
    step();
    n_cmp++; if (bus.we !== 1'b1 || bus.wa !== 5'd31) begin
      n_err++; $display("FAIL link_wa: got %0h/%0d want 1/31", bus.we, bus.wa);
    end
    n_cmp++; if (bus.wd !== 32'h00400018) begin n_err++; $display("FAIL link_wd: got %h want 00400018", bus.wd); end
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd0, 3'd0, 5'd4, 5'd0, 32'h55, 32'h0);
    step();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL r0_we: got %0h want 0", bus.we); end
    n_cmp++; if (bus.retired_o !== 16'd11) begin n_err++; $display("FAIL r0_ret1: got %0d want 11", bus.retired_o); end
    nop();
    step();
    n_cmp++; if (bus.retired_o !== 16'd12) begin n_err++; $display("FAIL r0_ret2: got %0d want 12", bus.retired_o); end
  endtask

  task automatic test_flush();
    bus.memrd_vld_i = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 3'd0, 5'd0, 5'd12, 32'h3000, 32'h0);
    step();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL flush_we: got %0h want 0", bus.we); end
    n_cmp++; if (bus.wb_busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %0h want 0", bus.wb_busy_o); end
    nop();
    step();
    n_cmp++; if (bus.retired_o !== 16'd12) begin n_err++; $display("FAIL flush_ret: got %0d want 12", bus.retired_o); end
  endtask

  task automatic test_reset_mid_stall();
    bus.memrd_vld_i = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 2'd1, 2'd1, 3'd0, 5'd0, 5'd14, 32'h4000, 32'h0);
    step();
    nop();
    n_cmp++; if (bus.wb_busy_o !== 1'b1) begin n_err++; $display("FAIL mrst_pre_busy: got %0h want 1", bus.wb_busy_o); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.we !== 1'b0 || bus.wa !== 5'd0 || bus.wd !== 32'd0) begin
      n_err++; $display("FAIL mrst_out: got %0h/%0d/%h want 0/0/00000000", bus.we, bus.wa, bus.wd);
    end
    n_cmp++; if (bus.wb_busy_o !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %0h want 0", bus.wb_busy_o); end
    n_cmp++; if (bus.retired_o !== 16'd0) begin n_err++; $display("FAIL mrst_ret: got %0d want 0", bus.retired_o); end
    step();
    rst = 1'b1;
    bus.memrd_vld_i = 1'b1;
    step();
    n_cmp++; if (bus.we !== 1'b0) begin n_err++; $display("FAIL mrst_after_we: got %0h want 0", bus.we); end
    n_cmp++; if (bus.retired_o !== 16'd0) begin n_err++; $display("FAIL mrst_after_ret: got %0d want 0", bus.retired_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_alu_writes();
    test_load_ext();
    test_load_stall();
    test_link_r0();
    test_flush();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage for the pipelined MIPS core. It holds its own MEM/WB pipeline register and selects the destination register (rt, rd or link register). It builds the write data from the ALU result, the aligned and extended load data, or the link address. It stalls the pipeline while load data is outstanding and exposes a retired-instruction counter. It sits between the memory stage and the register file, and drives both the register-file write port and the forwarding bus.

## Interface
Parameters:
- `AW`, 5, register-address width.
- `LINK_REG`, 31, destination register for link writes.
- `LINK_OFS`, 8, added to `pc_i` to form the link value.
- `CNT_W`, 16, retired-instruction counter width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `valid_i`  in  1  — MEM stage holds a real instruction.
- `flush_i`  in  1  — discard incoming MEM instruction; a bubble is loaded.
- `regwe_i`  in  1  — instruction writes the register file.
- `cregwa_i`  in  2  — destination select: 0 rt, 1 rd, 2 `LINK_REG`, 3 rt.
- `cregwd_i`  in  2  — data select: 0 ALU, 1 load, 2 link, 3 zero.
- `ldsel_i`  in  3  — load mode: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5–7 treated as lw.
- `rt_i`, `rd_i`  in  `AW`  — register fields.
- `aluout_i`  in  32  — ALU result, which is also the load address.
- `pc_i`  in  32  — instruction PC.
- `memrd_i`  in  32  — data-memory read word, sampled while the captured load is in WB.
- `memrd_vld_i`  in  1  — `memrd_i` is valid this cycle.
- `we`, `wa`, `wd`  out  1/`AW`/32  — register-file write port.
- `we_wb`, `wa_wb`, `wd_wb`  out  1/`AW`/32  — forwarding bus, identical to `we`/`wa`/`wd`.
- `wb_busy_o`  out  1  — WB is waiting for load data; upstream must freeze.
- `retired_o`  out  `CNT_W`  — count of instructions that completed WB.

## Operation
- **Pipeline register.** Holds `valid`, `regwe`, `cregwa`, `cregwd`, `ldsel`, the selected destination address, `aluout` and `pc`.
- **Advance.** `adv = !wb_busy_o`.
  - On a rising edge with `adv`, the register captures the MEM inputs.
  - If `flush_i` is set, it captures `valid=0` instead and all other fields are don't-care.
  - With `!adv`, the register holds.
- **Load status.** `is_load = valid & (cregwd==1)`. `wb_busy_o = is_load & !memrd_vld_i`, computed combinationally.
- **Destination address.** Resolved at capture time from `cregwa_i`, `rt_i`, `rd_i` and `LINK_REG`.
- **Load alignment** (big-endian, byte 0 = `memrd_i[31:24]`, offset `a = aluout[1:0]` as captured):
  - lw: whole word; `a` is ignored.
  - lh/lhu: `a[1]=0` selects `[31:16]`, `a[1]=1` selects `[15:0]`. `a[0]` is ignored. lh sign-extends, lhu zero-extends.
  - lb/lbu: byte `a` is selected. lb sign-extends, lbu zero-extends.
- **Write data:**
  - ALU: `aluout`.
  - Load: aligned value.
  - Link: `pc + LINK_OFS`, modulo 2^32.
  - Zero: 0.
- **Write enable.** `we = valid & regwe & !wb_busy_o & (wa != 0)`. Writes to r0 are always suppressed.
- **Output values.** `wa` and `wd` are driven from the register at all times. They are don't-care when `we=0`, but they must still be deterministic.
- **Retired counter.** `retired_o` increments by 1 on each rising edge where `valid & !wb_busy_o`. This includes instructions that do not write. The counter wraps at 2^`CNT_W`.
- **Reset.** While `rst=0`, all register fields are 0, `valid=0` and `retired_o=0`. As a result `we=0`, `wa=0`, `wd=0` and `wb_busy_o=0`. Reset asserted mid-stall drops the pending load with no write and no count.

## Timing
- **Latency.** An instruction presented on the MEM inputs at edge N is written to the register file at edge N+1, with `we` high during cycle N..N+1.
- **Load stall.** A load whose `memrd_vld_i` is low holds WB. `we` stays 0 for every stall cycle. The write occurs in the first cycle in which `memrd_vld_i=1`, and the register advances at the end of that cycle.
- **Flush during stall.** `flush_i` while `wb_busy_o=1` has no effect on the held instruction. Flush applies only on an advancing edge.
- **Forwarding.** `we_wb`/`wa_wb`/`wd_wb` are combinational copies of `we`/`wa`/`wd`, so they are valid in the same cycle.
- **Non-load instructions.** These never assert `wb_busy_o`. `memrd_vld_i` is ignored for them.

## Test plan
- **Reset.** Assert `rst=0` for 3 cycles, then release. Required: `we=0`, `wa=0`, `wd=0`, `wb_busy_o=0` and `retired_o=0` until the first valid instruction.
- **ALU writes.** Send back-to-back ALU instructions (rd=5 with 0x1234, then rt=7 with 0xDEAD). Required: `we` is high on consecutive cycles with `wa=5`/`wd=0x1234` then `wa=7`/`wd=0xDEAD`, and `retired_o` reaches 2.
- **Load extension.** `memrd_i=0x80FF7F01` with `memrd_vld_i=1`:
  - lb, `a=0` → 0xFFFFFF80.
  - lbu, `a=1` → 0x000000FF.
  - lb, `a=2` → 0x0000007F.
  - lh, `a=2` → 0x00007F01.
  - lhu, `a=0` → 0x000080FF.
  - lw → 0x80FF7F01.
- **Load stall.** A load with `memrd_vld_i` low for 3 cycles. Required: `wb_busy_o=1` and `we=0` for 3 cycles. On the 4th cycle `we=1` with the correct data. `retired_o` increments once, and a MEM instruction held at the inputs is captured only after the 4th edge.
- **Link and r0.** Link write with `pc_i=0x00400010`. Required: `wa=31`, `wd=0x00400018`. An ALU write to rd=0 gives `we=0` while `retired_o` still increments.
- **Flush and reset mid-stall.**
  - `flush_i` with a valid load at the inputs: no write, `retired_o` unchanged.
  - `rst` pulsed during a load stall: outputs return to 0 immediately and no write follows.
